lc3_regfile_wr: RTL and testbench

// - LC-3 general register file: R0..R7 storage, write-side destination decode,
//   NZP condition-code generation and a per-register busy scoreboard.
// - The write side decodes the 3-bit destination to a one-hot enable (1-to-8

---
 rtl/lc3_regfile_wr_pkg.sv | 17 +
 rtl/lc3_regfile_wr_dec3to8.sv | 17 +
 rtl/lc3_regfile_wr.sv | 116 +++++++++++
 tb/tb_lc3_regfile_wr.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_regfile_wr_pkg.sv
// Shared types and constants for the LC-3 register file slice.
`timescale 1ns/1ps
package lc3_types;

   typedef logic [15:0] lc3_word;
   typedef logic [2:0]  lc3_reg_idx;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } lc3_cc;

   localparam int    NREGS    = 8;
   localparam lc3_cc CC_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

endpackage

// File: rtl/lc3_regfile_wr_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable.
// All outputs are zero when en is low.
`timescale 1ns/1ps
module dec3to8 (
   input  logic       en,
   input  logic [2:0] idx,
   output logic [7:0] onehot
);

   // Each output bit is one comparator against its own index.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign onehot[gi] = en && (idx == 3'(gi));
      end
   endgenerate

endmodule

// File: rtl/lc3_regfile_wr.sv
// LC-3 general register file R0..R7.
// Contents:
// - write-side one-hot destination decode
// - two combinational read ports with same-cycle write forwarding
// - NZP condition codes
// - per-register busy scoreboard
// Storage is a flop array because it needs the asynchronous reset.
`timescale 1ns/1ps
module lc3_regfile_wr
   import lc3_types::*;
#(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_reg,
   input  logic [2:0]       dest,
   input  logic [width-1:0] wdata,
   input  logic             ld_cc,
   input  logic             rsv,
   input  logic [2:0]       rsv_dest,
   input  logic [2:0]       sr1,
   input  logic [2:0]       sr2,
   output logic [width-1:0] sr1_out,
   output logic [width-1:0] sr2_out,
   output logic             sr1_busy,
   output logic             sr2_busy,
   output logic             n,
   output logic             z,
   output logic             p
);

   logic [NREGS-1:0] wr_en;
   logic [NREGS-1:0] rsv_en;
   logic [width-1:0] reg_file [NREGS];
   logic [NREGS-1:0] busy_reg;
   lc3_cc            cc_reg;
   lc3_cc            cc_next;

   dec3to8 u_wr_dec (
      .en     (ld_reg),
      .idx    (dest),
      .onehot (wr_en)
   );

   dec3to8 u_rsv_dec (
      .en     (rsv),
      .idx    (rsv_dest),
      .onehot (rsv_en)
   );

   // Register storage: only the decoded destination loads wdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            reg_file[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wr_en[i]) begin
               reg_file[i] <= wdata;
            end
         end
      end
   end

   // Scoreboard: a write retires the producer, but a same-cycle reserve
   // of that index is a new producer in flight and therefore wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= (busy_reg & ~wr_en) | rsv_en;
      end
   end

   // Condition codes derived from the word on the write bus.
   always_comb begin
      cc_next   = cc_reg;
      cc_next.n = wdata[width-1];
      cc_next.z = (wdata == '0);
      cc_next.p = !wdata[width-1] && (wdata != '0);
   end

   // Condition-code register, loaded independently of the register write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_reg <= CC_RESET;
      end else if (ld_cc) begin
         cc_reg <= cc_next;
      end
   end

   // Read port 1: forward the in-flight write; a forwarded operand is not busy.
   always_comb begin
      sr1_out  = reg_file[sr1];
      sr1_busy = busy_reg[sr1] && !wr_en[sr1];
      if (wr_en[sr1]) begin
         sr1_out = wdata;
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      sr2_out  = reg_file[sr2];
      sr2_busy = busy_reg[sr2] && !wr_en[sr2];
      if (wr_en[sr2]) begin
         sr2_out = wdata;
      end
   end

   assign n = cc_reg.n;
   assign z = cc_reg.z;
   assign p = cc_reg.p;

endmodule

// File: tb/tb_lc3_regfile_wr.sv
// Directed and randomized checks of the LC-3 register file.
`timescale 1ns/1ps
module tb_lc3_regfile_wr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_reg;
   logic [2:0]  dest;
   logic [15:0] wdata;
   logic        ld_cc;
   logic        rsv;
   logic [2:0]  rsv_dest;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] sr1_out;
   logic [15:0] sr2_out;
   logic        sr1_busy;
   logic        sr2_busy;
   logic        n;
   logic        z;
   logic        p;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state, updated at each rising edge from the applied inputs.
   logic [15:0] m_reg [8];
   logic [7:0]  m_busy;
   logic [2:0]  m_cc;

   always #5 clk = ~clk;

   lc3_regfile_wr #(.width(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_reg   (ld_reg),
      .dest     (dest),
      .wdata    (wdata),
      .ld_cc    (ld_cc),
      .rsv      (rsv),
      .rsv_dest (rsv_dest),
      .sr1      (sr1),
      .sr2      (sr2),
      .sr1_out  (sr1_out),
      .sr2_out  (sr2_out),
      .sr1_busy (sr1_busy),
      .sr2_busy (sr2_busy),
      .n        (n),
      .z        (z),
      .p        (p)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic l, input logic [2:0] d, input logic [15:0] wd,
                        input logic lc, input logic r, input logic [2:0] rd,
                        input logic [2:0] s1, input logic [2:0] s2);
      ld_reg   = l;
      dest     = d;
      wdata    = wd;
      ld_cc    = lc;
      rsv      = r;
      rsv_dest = rd;
      sr1      = s1;
      sr2      = s2;
   endtask

   // Advance one clock, update the reference, then step off the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_reg[i] = '0;
         m_busy = '0;
         m_cc   = 3'b010;
      end else begin
         if (ld_reg) begin
            m_reg[dest]  = wdata;
            m_busy[dest] = 1'b0;
         end
         if (rsv) m_busy[rsv_dest] = 1'b1;
         if (ld_cc) m_cc = {wdata[15], wdata == 16'h0, !wdata[15] && (wdata != 16'h0)};
      end
      #1;
   endtask

   initial begin
      logic [15:0] e1;
      logic [15:0] e2;
      logic        b1;
      logic        b2;

      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_busy = '0;
      m_cc   = 3'b010;
      rst_n  = 1'b0;
      drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_nzp", {13'b0, n, z, p}, 16'h0002);
      chk("reset_sr1", sr1_out, 16'h0000);
      chk("reset_busy", {14'b0, sr1_busy, sr2_busy}, 16'h0000);

      // Write all registers, then read them back on both ports.
      for (int i = 0; i < 8; i++) begin
         tick();
         drive(1, 3'(i), 16'(16'h1111 * i), 0, 0, 0, 0, 0);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 16'h0, 0, 0, 0, 3'(i), 3'(7 - i));
         #2;
         chk($sformatf("rd_sr1_r%0d", i), sr1_out, 16'(16'h1111 * i));
         chk($sformatf("rd_sr2_r%0d", 7 - i), sr2_out, 16'(16'h1111 * (7 - i)));
      end

      // Same-cycle forwarding to both ports.
      drive(1, 3, 16'h00AA, 0, 0, 0, 0, 0);
      tick();
      drive(1, 3, 16'h5555, 0, 0, 0, 3, 3);
      #2;
      chk("fwd_sr1", sr1_out, 16'h5555);
      chk("fwd_sr2", sr2_out, 16'h5555);
      tick();
      drive(0, 3, 16'h0000, 0, 0, 0, 3, 3);
      #2;
      chk("fwd_commit", sr1_out, 16'h5555);
      chk("fwd_r2_intact", {15'b0, sr1_busy}, 16'h0000);

      // Condition codes.
      drive(0, 0, 16'h8000, 1, 0, 0, 0, 0);
      tick();
      chk("cc_neg", {13'b0, n, z, p}, 16'h0004);
      drive(0, 0, 16'h0000, 1, 0, 0, 0, 0);
      tick();
      chk("cc_zero", {13'b0, n, z, p}, 16'h0002);
      drive(0, 0, 16'h7FFF, 1, 0, 0, 0, 0);
      tick();
      chk("cc_pos", {13'b0, n, z, p}, 16'h0001);
      drive(1, 0, 16'h8000, 0, 0, 0, 0, 0);
      tick();
      chk("cc_hold", {13'b0, n, z, p}, 16'h0001);

      // Scoreboard.
      drive(0, 0, 16'h0, 0, 1, 5, 5, 5);
      #2;
      chk("sb_rsv_same_cycle", {15'b0, sr1_busy}, 16'h0000);
      tick();
      drive(0, 0, 16'h0, 0, 0, 0, 5, 5);
      #2;
      chk("sb_rsv_next", {15'b0, sr1_busy}, 16'h0001);
      drive(1, 5, 16'h1234, 0, 0, 0, 5, 5);
      #2;
      chk("sb_wr_fwd_busy", {15'b0, sr1_busy}, 16'h0000);
      chk("sb_wr_fwd_data", sr1_out, 16'h1234);
      tick();
      drive(0, 0, 16'h0, 0, 0, 0, 5, 5);
      #2;
      chk("sb_wr_after", {15'b0, sr1_busy}, 16'h0000);
      drive(0, 0, 16'h0, 0, 1, 5, 5, 5);
      tick();
      drive(1, 5, 16'h4321, 0, 1, 5, 5, 5);
      #2;
      chk("sb_both_fwd", {15'b0, sr1_busy}, 16'h0000);
      tick();
      drive(0, 0, 16'h0, 0, 0, 0, 5, 5);
      #2;
      chk("sb_rsv_wins", {15'b0, sr1_busy}, 16'h0001);
      drive(1, 5, 16'h0F0F, 0, 1, 2, 0, 0);
      tick();
      drive(0, 0, 16'h0, 0, 0, 0, 5, 2);
      #2;
      chk("sb_diff_wr", {15'b0, sr1_busy}, 16'h0000);
      chk("sb_diff_rsv", {15'b0, sr2_busy}, 16'h0001);

      // Asynchronous reset in the middle of a write.
      drive(1, 6, 16'hBEEF, 1, 0, 0, 1, 2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_sr1", sr1_out, 16'h0000);
      chk("rst_async_sr2", sr2_out, 16'h0000);
      chk("rst_async_nzp", {13'b0, n, z, p}, 16'h0002);
      chk("rst_async_busy", {15'b0, sr2_busy}, 16'h0000);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 6, 16'hBEEF, 0, 0, 0, 6, 6);
      tick();
      chk("rst_no_commit", sr1_out, 16'h0000);

      // Randomized traffic against the reference.
      for (int c = 0; c < 10000; c++) begin
         drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom));
         if ($urandom_range(0, 7) == 0) wdata = 16'h0000;
         #2;
         e1 = (ld_reg && dest == sr1) ? wdata : m_reg[sr1];
         e2 = (ld_reg && dest == sr2) ? wdata : m_reg[sr2];
         b1 = m_busy[sr1] && !(ld_reg && dest == sr1);
         b2 = m_busy[sr2] && !(ld_reg && dest == sr2);
         chk("rnd_sr1", sr1_out, e1);
         chk("rnd_sr2", sr2_out, e2);
         chk("rnd_busy", {14'b0, sr1_busy, sr2_busy}, {14'b0, b1, b2});
         chk("rnd_nzp", {13'b0, n, z, p}, {13'b0, m_cc});
         chk("rnd_onehot", 16'($countones({n, z, p})), 16'd1);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
